feature_lut_loader: RTL and testbench

FEATURE_LUT_LOADER -- requirements
Module: feature_lut_loader

---
 rtl/feature_lut_loader.sv | 156 +++++++++++++++
 tb/tb_feature_lut_loader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/feature_lut_loader.sv
// Byte-stream to 32-bit LUT word loader: packs bytes little-endian and writes consecutive words.
// Optional running word checksum enabled by defining LUT_LOADER_CHECKSUM_EN.
module feature_lut_loader #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   word_count_i,
    input  logic [7:0]            in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] checksum_o
);

    typedef enum logic {StIdle, StLoad} state_e;

    state_e                state_q, state_d;
    logic [1:0]            lane_q, lane_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [23:0]           byte_buf_q, byte_buf_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic                  word_fire;
    logic                  last_word;
    logic [DATA_WIDTH-1:0] packed_word;

    assign accept      = (state_q == StLoad) && in_valid_i;
    // Abort wins over a completing fourth byte.
    assign word_fire   = accept && (lane_q == 2'd3) && !abort_i;
    assign last_word   = word_fire && ((idx_q + 1'b1) == count_q);
    assign packed_word = {in_data_i, byte_buf_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_i && (word_count_i != '0)) state_d = StLoad;
            StLoad: if (abort_i || last_word) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o     = (state_q == StLoad);
        in_ready_o = (state_q == StLoad);
    end

    always_comb begin
        lane_d      = lane_q;
        idx_d       = idx_q;
        count_d     = count_q;
        base_d      = base_q;
        byte_buf_d  = byte_buf_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        if (state_q == StIdle) begin
            if (start_i) begin
                base_d  = base_addr_i;
                count_d = word_count_i;
                lane_d  = 2'd0;
                idx_d   = '0;
                done_d  = (word_count_i == '0);
            end
        end else if (abort_i) begin
            lane_d = 2'd0;
        end else if (accept) begin
            if (lane_q == 2'd3) begin
                lane_d      = 2'd0;
                idx_d       = idx_q + 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = base_q + idx_q[ADDR_WIDTH-1:0];
                mem_wdata_d = packed_word;
                done_d      = last_word;
            end else begin
                lane_d = lane_q + 2'd1;
                case (lane_q)
                    2'd0:    byte_buf_d[7:0]   = in_data_i;
                    2'd1:    byte_buf_d[15:8]  = in_data_i;
                    default: byte_buf_d[23:16] = in_data_i;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q      <= 2'd0;
            idx_q       <= '0;
            count_q     <= '0;
            base_q      <= '0;
            byte_buf_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
        end else begin
            lane_q      <= lane_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            base_q      <= base_d;
            byte_buf_q  <= byte_buf_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
        end
    end

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign done_o      = done_q;

`ifdef LUT_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if ((state_q == StIdle) && start_i) begin
            csum_q <= '0;
        end else if (word_fire) begin
            csum_q <= csum_q + packed_word;
        end
    end

    assign checksum_o = csum_q;
`else
    assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_feature_lut_loader.sv
// Randomized bench for feature_lut_loader against a word-level reference model.
module tb_feature_lut_loader;

    localparam int AW = 17;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   word_count = '0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, mem_we, busy, done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, checksum;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    bit          m_busy;
    longint      m_base, m_count, m_k;
    byte unsigned m_b[$];
    longint      m_csum, m_addr, m_data;
    bit          e_we, e_done;

    feature_lut_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .abort_i      (abort),
        .base_addr_i  (base_addr),
        .word_count_i (word_count),
        .in_data_i    (in_data),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .busy_o       (busy),
        .done_o       (done),
        .checksum_o   (checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_base = 0; m_count = 0; m_k = 0; m_b.delete();
        m_csum = 0; m_addr = 0; m_data = 0; e_we = 0; e_done = 0;
    endtask

    task automatic model_step(input bit st, input bit ab, input bit v, input logic [7:0] d);
        e_we = 0;
        e_done = 0;
        if (!m_busy) begin
            if (st) begin
                m_csum = 0;
                if (word_count == 0) e_done = 1;
                else begin
                    m_busy = 1; m_base = base_addr; m_count = word_count; m_k = 0; m_b.delete();
                end
            end
        end else if (ab) begin
            m_busy = 0;
        end else if (v) begin
            m_b.push_back(d);
            if (m_b.size() == 4) begin
                m_data = m_b[0] + (longint'(m_b[1]) << 8) + (longint'(m_b[2]) << 16)
                       + (longint'(m_b[3]) << 24);
                m_addr = (m_base + m_k) % (longint'(1) << AW);
                m_csum = (m_csum + m_data) % (longint'(1) << 32);
                e_we = 1;
                m_k++;
                m_b.delete();
                if (m_k == m_count) begin
                    m_busy = 0;
                    e_done = 1;
                end
            end
        end
    endtask

    task automatic check_outs();
        check("mem_we", 64'(mem_we), 64'(e_we));
        check("done", 64'(done), 64'(e_done));
        check("busy", 64'(busy), 64'(m_busy));
        check("in_ready", 64'(in_ready), 64'(m_busy));
        check("mem_addr", 64'(mem_addr), 64'(m_addr));
        check("mem_wdata", 64'(mem_wdata), 64'(m_data));
`ifdef LUT_LOADER_CHECKSUM_EN
        check("checksum", 64'(checksum), 64'(m_csum));
`else
        check("checksum", 64'(checksum), 64'd0);
`endif
    endtask

    // Drive one cycle's inputs at a falling edge, then check at the next falling edge.
    task automatic step(input bit st, input bit ab, input bit v, input logic [7:0] d);
        start = st; abort = ab; in_valid = v; in_data = d;
        model_step(st, ab, v, d);
        @(negedge clk);
        check_outs();
    endtask

    task automatic begin_load(input logic [AW-1:0] b, input logic [AW:0] n);
        base_addr = b;
        word_count = n;
        step(1, 0, 0, 8'h00);
    endtask

    initial begin
        logic [7:0] seq [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        int guard;
        model_reset();
        #12;
        check_outs();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 8'h00);

        // Reference two-word load, one byte per cycle.
        begin_load(17'h00010, 18'd2);
        foreach (seq[i]) step(0, 0, 1, seq[i]);
`ifdef LUT_LOADER_CHECKSUM_EN
        check("csum_ref", 64'(checksum), 64'hCCAA8866);
`endif
        check("last_wdata", 64'(mem_wdata), 64'h88776655);
        step(0, 0, 0, 8'h00);

        // Address wrap at the top of the LUT.
        begin_load(17'h1FFFF, 18'd2);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 8'($urandom));
        check("wrap_addr", 64'(mem_addr), 64'h0);

        // Zero-length load.
        begin_load(17'h00123, 18'd0);
        step(0, 0, 0, 8'h00);
        step(0, 0, 1, 8'h5A);

        // Abort coinciding with the sixth byte, then a fresh load.
        begin_load(17'h00200, 18'd3);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'($urandom));
        step(0, 1, 1, 8'hAB);
        step(0, 0, 1, 8'hCD);
        step(0, 1, 0, 8'h00);
        begin_load(17'h00300, 18'd1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 8'(8'h10 + i));
        check("post_abort_wdata", 64'(mem_wdata), 64'h13121110);

        // Reset in the middle of the second word.
        begin_load(17'h00400, 18'd3);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 8'($urandom));
        #2;
        rst_n = 1'b0;
        start = 0; abort = 0; in_valid = 0;
        #1;
        model_reset();
        check_outs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step(0, 0, 1, 8'($urandom));

        // Randomized loads with 50% valid, stray starts and rare aborts.
        for (int t = 0; t < 40; t++) begin
            logic [AW-1:0] b;
            b = ($urandom % 4 == 0) ? AW'(17'h1FFFF - $urandom_range(0, 3)) : AW'($urandom);
            begin_load(b, 18'($urandom_range(0, 5)));
            guard = 0;
            while (m_busy && guard < 200) begin
                base_addr = AW'($urandom);
                word_count = 18'($urandom_range(0, 7));
                step($urandom % 6 == 0, $urandom % 60 == 0, $urandom % 2, 8'($urandom));
                guard++;
            end
            if (guard >= 200) check("load_timeout", 64'(guard), 64'd0);
            step(0, 0, $urandom % 2, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
